// File: rtl/sodor_mem_arbiter.sv
// Arbitrates the single Sodor memory port between instruction fetch and data memory.
// Responses return in order and are routed back to the requester through an owner FIFO.
module sodor_mem_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned OUTSTANDING   = 2,
    parameter int unsigned DM_STREAK_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_resp_data,

    input  logic              dm_req_valid,
    output logic              dm_req_ready,
    input  logic [ADDR_W-1:0] dm_req_addr,
    input  logic              dm_req_we,
    input  logic [2:0]        dm_req_be,
    input  logic [DATA_W-1:0] dm_req_wdata,
    output logic              dm_resp_valid,
    output logic [DATA_W-1:0] dm_resp_data,

    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [2:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              err
);

    localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
    localparam int unsigned STK_W = $clog2(DM_STREAK_MAX + 1);

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    logic [OUTSTANDING-1:0] owner_q;
    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [CNT_W-1:0]       count_q;
    logic [STK_W-1:0]       streak_q;
    logic                   err_q;

    logic can_issue;
    logic sel_if;
    logic sel_dm;
    logic transfer;
    logic pop;
    logic head_owner;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(OUTSTANDING - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Outputs are forced low while reset is asserted so the reset cycle reads all-zero.
    always_comb begin
        can_issue  = (count_q < CNT_W'(OUTSTANDING)) || mem_rvalid;
        sel_if     = if_req_valid && (!dm_req_valid || (streak_q == STK_W'(DM_STREAK_MAX)));
        sel_dm     = dm_req_valid && !sel_if;
        mem_req    = !reset && can_issue && (sel_if || sel_dm);
        transfer   = mem_req && mem_gnt;
        pop        = !reset && mem_rvalid && (count_q != '0);
        head_owner = owner_q[head_q];
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = 3'b000;
        mem_wdata = '0;
        if (mem_req) begin
            if (sel_if) begin
                mem_addr = if_req_addr;
                mem_be   = 3'b011;
            end else begin
                mem_addr  = dm_req_addr;
                mem_we    = dm_req_we;
                mem_be    = dm_req_be;
                mem_wdata = dm_req_wdata;
            end
        end
    end

    always_comb begin
        if_req_ready  = transfer && sel_if;
        dm_req_ready  = transfer && sel_dm;
        if_resp_valid = pop && (head_owner == OWNER_IF);
        dm_resp_valid = pop && (head_owner == OWNER_DM);
        if_resp_data  = if_resp_valid ? mem_rdata : '0;
        dm_resp_data  = dm_resp_valid ? mem_rdata : '0;
        err           = err_q && !reset;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            streak_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (transfer) begin
                owner_q[tail_q] <= sel_dm ? OWNER_DM : OWNER_IF;
                tail_q          <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q <= ptr_inc(head_q);
            end
            if (transfer && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!transfer && pop) begin
                count_q <= count_q - 1'b1;
            end

            if (!if_req_valid || (transfer && sel_if)) begin
                streak_q <= '0;
            end else if (transfer && sel_dm && (streak_q != STK_W'(DM_STREAK_MAX))) begin
                streak_q <= streak_q + 1'b1;
            end

            if (mem_rvalid && (count_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sodor_mem_arbiter.sv
// Directed bench for sodor_mem_arbiter: reset, IF/DM routing, streak fairness,
// stalled store, full owner FIFO with same-cycle pop, and the sticky error.
module tb_sodor_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic [31:0] dm_req_addr;
    logic        dm_req_we;
    logic [2:0]  dm_req_be;
    logic [31:0] dm_req_wdata;
    logic        dm_resp_valid;
    logic [31:0] dm_resp_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    sodor_mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .OUTSTANDING(2),
        .DM_STREAK_MAX(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .if_req_valid(if_req_valid),
        .if_req_ready(if_req_ready),
        .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid),
        .if_resp_data(if_resp_data),
        .dm_req_valid(dm_req_valid),
        .dm_req_ready(dm_req_ready),
        .dm_req_addr(dm_req_addr),
        .dm_req_we(dm_req_we),
        .dm_req_be(dm_req_be),
        .dm_req_wdata(dm_req_wdata),
        .dm_resp_valid(dm_resp_valid),
        .dm_resp_data(dm_resp_data),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_be(mem_be),
        .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .err(err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        if_req_valid = 1'b0;
        if_req_addr  = '0;
        dm_req_valid = 1'b0;
        dm_req_addr  = '0;
        dm_req_we    = 1'b0;
        dm_req_be    = 3'b000;
        dm_req_wdata = '0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_be"}, mem_be, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_if_resp_valid"}, if_resp_valid, 0);
        check({tag, "_dm_resp_valid"}, dm_resp_valid, 0);
        check({tag, "_err"}, err, 0);
    endtask

    bit exp_dm [8] = '{1, 1, 1, 1, 0, 1, 1, 0};

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        // Active request during reset must not leak onto the memory port.
        if_req_valid = 1'b1;
        if_req_addr  = 32'h40;
        mem_gnt      = 1'b1;
        #1;
        check_quiet("rst");
        check("rst_if_ready", if_req_ready, 0);
        tick();
        idle_inputs();
        tick();
        reset = 1'b0;
        #1;
        check_quiet("idle");
        tick();

        // Single fetch and its response one cycle later.
        if_req_valid = 1'b1;
        if_req_addr  = 32'h100;
        mem_gnt      = 1'b1;
        #1;
        check("if1_mem_req", mem_req, 1);
        check("if1_mem_addr", mem_addr, 32'h100);
        check("if1_mem_be", mem_be, 3'b011);
        check("if1_mem_we", mem_we, 0);
        check("if1_if_ready", if_req_ready, 1);
        check("if1_dm_ready", dm_req_ready, 0);
        tick();
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0013;
        #1;
        check("if1_resp_valid", if_resp_valid, 1);
        check("if1_resp_data", if_resp_data, 32'h13);
        check("if1_dm_resp_valid", dm_resp_valid, 0);
        check("if1_dm_resp_data", dm_resp_data, 0);
        tick();
        idle_inputs();

        // Both requesters always valid: DM x4, then IF, then DM again.
        for (int i = 0; i < 8; i++) begin
            if_req_valid = (i < 7);
            if_req_addr  = 32'h200;
            dm_req_valid = (i < 7);
            dm_req_addr  = 32'h3000;
            dm_req_be    = 3'b010;
            mem_gnt      = 1'b1;
            mem_rvalid   = (i > 0);
            mem_rdata    = 32'h1000 + i;
            #1;
            if (i < 7) begin
                check($sformatf("mix%0d_dm_ready", i), dm_req_ready, exp_dm[i]);
                check($sformatf("mix%0d_if_ready", i), if_req_ready, !exp_dm[i]);
                check($sformatf("mix%0d_mem_addr", i), mem_addr, exp_dm[i] ? 32'h3000 : 32'h200);
                check($sformatf("mix%0d_mem_be", i), mem_be, exp_dm[i] ? 3'b010 : 3'b011);
            end
            if (i > 0) begin
                check($sformatf("mix%0d_dm_resp", i), dm_resp_valid, exp_dm[i-1]);
                check($sformatf("mix%0d_if_resp", i), if_resp_valid, !exp_dm[i-1]);
                check($sformatf("mix%0d_dm_data", i), dm_resp_data, exp_dm[i-1] ? 32'h1000 + i : 0);
                check($sformatf("mix%0d_if_data", i), if_resp_data, exp_dm[i-1] ? 0 : 32'h1000 + i);
            end
            tick();
        end
        idle_inputs();

        // Store stalled by the memory for three cycles.
        for (int i = 0; i < 4; i++) begin
            dm_req_valid = 1'b1;
            dm_req_addr  = 32'h2000;
            dm_req_we    = 1'b1;
            dm_req_be    = 3'b001;
            dm_req_wdata = 32'hAB;
            mem_gnt      = (i == 3);
            #1;
            check($sformatf("st%0d_mem_req", i), mem_req, 1);
            check($sformatf("st%0d_mem_addr", i), mem_addr, 32'h2000);
            check($sformatf("st%0d_mem_we", i), mem_we, 1);
            check($sformatf("st%0d_mem_be", i), mem_be, 3'b001);
            check($sformatf("st%0d_mem_wdata", i), mem_wdata, 32'hAB);
            check($sformatf("st%0d_dm_ready", i), dm_req_ready, i == 3);
            tick();
        end
        idle_inputs();
        mem_rvalid = 1'b1;
        #1;
        check("st_ack_dm", dm_resp_valid, 1);
        check("st_ack_if", if_resp_valid, 0);
        tick();
        idle_inputs();

        // Fill the owner FIFO with two fetches.
        if_req_valid = 1'b1;
        if_req_addr  = 32'h10;
        mem_gnt      = 1'b1;
        #1;
        check("full_a_ready", if_req_ready, 1);
        tick();
        if_req_addr = 32'h14;
        #1;
        check("full_b_ready", if_req_ready, 1);
        tick();
        idle_inputs();
        dm_req_valid = 1'b1;
        dm_req_addr  = 32'h500;
        mem_gnt      = 1'b1;
        #1;
        check("full_c_mem_req", mem_req, 0);
        check("full_c_dm_ready", dm_req_ready, 0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55;
        #1;
        check("full_d_mem_req", mem_req, 1);
        check("full_d_dm_ready", dm_req_ready, 1);
        check("full_d_if_resp", if_resp_valid, 1);
        check("full_d_if_data", if_resp_data, 32'h55);
        tick();
        mem_rvalid  = 1'b0;
        dm_req_addr = 32'h504;
        #1;
        check("full_e_mem_req", mem_req, 0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h66;
        #1;
        check("full_f_dm_ready", dm_req_ready, 1);
        check("full_f_if_resp", if_resp_valid, 1);
        check("full_f_if_data", if_resp_data, 32'h66);
        tick();
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h77;
        #1;
        check("full_g_dm_resp", dm_resp_valid, 1);
        check("full_g_dm_data", dm_resp_data, 32'h77);
        tick();
        mem_rdata = 32'h88;
        #1;
        check("full_h_dm_resp", dm_resp_valid, 1);
        check("full_h_dm_data", dm_resp_data, 32'h88);
        tick();
        idle_inputs();
        #1;
        check("drained_err", err, 0);

        // In-flight fetch discarded by reset; its late response is an error.
        if_req_valid = 1'b1;
        if_req_addr  = 32'h900;
        mem_gnt      = 1'b1;
        #1;
        check("err_if_ready", if_req_ready, 1);
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD;
        #1;
        check("err_stray_if", if_resp_valid, 0);
        check("err_stray_dm", dm_resp_valid, 0);
        check("err_stray_err_pre", err, 0);
        tick();
        mem_rvalid = 1'b0;
        #1;
        check("err_set", err, 1);
        tick();
        #1;
        check("err_sticky", err, 1);
        reset = 1'b1;
        #1;
        check("err_rst_cycle", err, 0);
        tick();
        reset = 1'b0;
        #1;
        check("err_cleared", err, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
